// File: rtl/instr_encoder.sv
// RV32I + Zicsr + Zifencei instruction encoder: packs a kind plus operands into a 32-bit word.
// The word then passes through a two-stage valid/ready pipeline that tags each word with its byte address.
package opcode_type;
  typedef enum logic [5:0] {
    K_LUI = 6'd0, K_AUIPC, K_JAL, K_JALR,
    K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
    K_LB, K_LH, K_LW, K_LBU, K_LHU,
    K_SB, K_SH, K_SW,
    K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
    K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
    K_FENCE, K_FENCE_I, K_ECALL, K_EBREAK,
    K_CSRRW, K_CSRRS, K_CSRRC, K_CSRRWI, K_CSRRSI, K_CSRRCI
  } instr_kind_t;
endpackage

module instr_encoder
  import opcode_type::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  instr_kind_t      in_kind,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             out_err,
  output logic [CNT_W-1:0] accepted_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST, C_OPI, C_SH, C_OP, C_CSR, C_FIX, C_BAD
  } cls_t;

  logic        s1_valid;
  instr_kind_t s1_kind;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [31:0] s1_imm;

  logic s2_load, in_fire, out_fire;
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_load);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  logic signed [31:0] simm;
  logic imm_i_ok, imm_b_ok, imm_j_ok;
  assign simm     = $signed(s1_imm);
  assign imm_i_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
  assign imm_b_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !s1_imm[0];
  assign imm_j_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !s1_imm[0];

  cls_t        cls;
  logic [2:0]  f3;
  logic [6:0]  f7, opcode;
  logic [31:0] fixed_word, word_d;
  logic        fix_bad, bad;

  always_comb begin
    cls        = C_BAD;
    f3         = 3'b000;
    f7         = 7'b0000000;
    fixed_word = 32'h0;
    fix_bad    = 1'b0;
    case (s1_kind)
      K_LUI:    cls = C_LUI;
      K_AUIPC:  cls = C_AUIPC;
      K_JAL:    cls = C_JAL;
      K_JALR:   cls = C_JALR;
      K_BEQ:    begin cls = C_BR;  f3 = 3'b000; end
      K_BNE:    begin cls = C_BR;  f3 = 3'b001; end
      K_BLT:    begin cls = C_BR;  f3 = 3'b100; end
      K_BGE:    begin cls = C_BR;  f3 = 3'b101; end
      K_BLTU:   begin cls = C_BR;  f3 = 3'b110; end
      K_BGEU:   begin cls = C_BR;  f3 = 3'b111; end
      K_LB:     begin cls = C_LD;  f3 = 3'b000; end
      K_LH:     begin cls = C_LD;  f3 = 3'b001; end
      K_LW:     begin cls = C_LD;  f3 = 3'b010; end
      K_LBU:    begin cls = C_LD;  f3 = 3'b100; end
      K_LHU:    begin cls = C_LD;  f3 = 3'b101; end
      K_SB:     begin cls = C_ST;  f3 = 3'b000; end
      K_SH:     begin cls = C_ST;  f3 = 3'b001; end
      K_SW:     begin cls = C_ST;  f3 = 3'b010; end
      K_ADDI:   begin cls = C_OPI; f3 = 3'b000; end
      K_SLTI:   begin cls = C_OPI; f3 = 3'b010; end
      K_SLTIU:  begin cls = C_OPI; f3 = 3'b011; end
      K_XORI:   begin cls = C_OPI; f3 = 3'b100; end
      K_ORI:    begin cls = C_OPI; f3 = 3'b110; end
      K_ANDI:   begin cls = C_OPI; f3 = 3'b111; end
      K_SLLI:   begin cls = C_SH;  f3 = 3'b001; end
      K_SRLI:   begin cls = C_SH;  f3 = 3'b101; end
      K_SRAI:   begin cls = C_SH;  f3 = 3'b101; f7 = 7'b0100000; end
      K_ADD:    begin cls = C_OP;  f3 = 3'b000; end
      K_SUB:    begin cls = C_OP;  f3 = 3'b000; f7 = 7'b0100000; end
      K_SLL:    begin cls = C_OP;  f3 = 3'b001; end
      K_SLT:    begin cls = C_OP;  f3 = 3'b010; end
      K_SLTU:   begin cls = C_OP;  f3 = 3'b011; end
      K_XOR:    begin cls = C_OP;  f3 = 3'b100; end
      K_SRL:    begin cls = C_OP;  f3 = 3'b101; end
      K_SRA:    begin cls = C_OP;  f3 = 3'b101; f7 = 7'b0100000; end
      K_OR:     begin cls = C_OP;  f3 = 3'b110; end
      K_AND:    begin cls = C_OP;  f3 = 3'b111; end
      K_FENCE:  begin
        cls        = C_FIX;
        fixed_word = {4'b0000, s1_imm[7:0], 13'b0, 7'b0001111};
        fix_bad    = |s1_imm[31:8];
      end
      K_FENCE_I: begin cls = C_FIX; fixed_word = 32'h0000_100F; end
      K_ECALL:   begin cls = C_FIX; fixed_word = 32'h0000_0073; end
      K_EBREAK:  begin cls = C_FIX; fixed_word = 32'h0010_0073; end
      K_CSRRW:   begin cls = C_CSR; f3 = 3'b001; end
      K_CSRRS:   begin cls = C_CSR; f3 = 3'b010; end
      K_CSRRC:   begin cls = C_CSR; f3 = 3'b011; end
      K_CSRRWI:  begin cls = C_CSR; f3 = 3'b101; end
      K_CSRRSI:  begin cls = C_CSR; f3 = 3'b110; end
      K_CSRRCI:  begin cls = C_CSR; f3 = 3'b111; end
      default:   cls = C_BAD;
    endcase
  end

  // Pack the field layout for the class; any illegal operand zeroes the word.
  always_comb begin
    opcode = 7'b0000000;
    word_d = 32'h0;
    bad    = 1'b0;
    unique case (cls)
      C_LUI:   begin opcode = 7'b0110111; bad = |s1_imm[11:0]; word_d = {s1_imm[31:12], s1_rd, opcode}; end
      C_AUIPC: begin opcode = 7'b0010111; bad = |s1_imm[11:0]; word_d = {s1_imm[31:12], s1_rd, opcode}; end
      C_JAL: begin
        opcode = 7'b1101111;
        bad    = !imm_j_ok;
        word_d = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, opcode};
      end
      C_JALR, C_LD, C_OPI: begin
        opcode = (cls == C_JALR) ? 7'b1100111 : (cls == C_LD) ? 7'b0000011 : 7'b0010011;
        bad    = !imm_i_ok;
        word_d = {s1_imm[11:0], s1_rs1, f3, s1_rd, opcode};
      end
      C_ST: begin
        opcode = 7'b0100011;
        bad    = !imm_i_ok;
        word_d = {s1_imm[11:5], s1_rs2, s1_rs1, f3, s1_imm[4:0], opcode};
      end
      C_BR: begin
        opcode = 7'b1100011;
        bad    = !imm_b_ok;
        word_d = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, f3, s1_imm[4:1], s1_imm[11], opcode};
      end
      C_SH: begin
        opcode = 7'b0010011;
        bad    = |s1_imm[31:5];
        word_d = {f7, s1_imm[4:0], s1_rs1, f3, s1_rd, opcode};
      end
      C_OP:  begin opcode = 7'b0110011; word_d = {f7, s1_rs2, s1_rs1, f3, s1_rd, opcode}; end
      C_CSR: begin
        opcode = 7'b1110011;
        bad    = |s1_imm[31:12];
        word_d = {s1_imm[11:0], s1_rs1, f3, s1_rd, opcode};
      end
      C_FIX:   begin bad = fix_bad; word_d = fixed_word; end
      default: bad = 1'b1;
    endcase
    if (bad) word_d = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_kind        <= K_LUI;
      s1_rd          <= 5'd0;
      s1_rs1         <= 5'd0;
      s1_rs2         <= 5'd0;
      s1_imm         <= 32'h0;
      out_valid      <= 1'b0;
      out_instr      <= 32'h0;
      out_err        <= 1'b0;
      out_addr       <= BASE_ADDR;
      accepted_count <= '0;
      err_count      <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_kind  <= in_kind;
        s1_rd    <= in_rd;
        s1_rs1   <= in_rs1;
        s1_rs2   <= in_rs2;
        s1_imm   <= in_imm;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_instr <= word_d;
          out_err   <= bad;
        end
      end
      if (out_fire) out_addr <= out_addr + 32'd4;
      if (in_fire && !(&accepted_count)) accepted_count <= accepted_count + CNT_W'(1);
      if (out_fire && out_err && !(&err_count)) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed vector table, directed pipeline corner cases and
// randomized traffic scored against an arithmetic encoding model.
module tb_instr_encoder;
  import opcode_type::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          CW   = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, out_err;
  instr_kind_t   in_kind = K_LUI;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0]   in_imm = '0, out_instr, out_addr;
  logic [CW-1:0] accepted_count, err_count;

  instr_encoder #(.BASE_ADDR(BASE), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .out_err(out_err), .accepted_count(accepted_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic err; logic [31:0] instr; } exp_t;
  typedef struct { int k; logic [4:0] rd, rs1, rs2; logic [31:0] imm; logic err; logic [31:0] instr; } vec_t;

  int          checks = 0, errors = 0;
  exp_t        q[$];
  exp_t        nxt;
  vec_t        tbl[$];
  logic [31:0] m_addr = BASE;
  int          m_acc = 0, m_err = 0;
  bit          held = 0, s_in_ready = 0, s_out_valid = 0;
  logic [31:0] h_instr, h_addr;
  logic        h_err;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int sat(int n);
    return (n > (2**CW - 1)) ? (2**CW - 1) : n;
  endfunction

  function automatic longint fld(longint v, int hi, int lo);
    return (v >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  // Reference encoder: kind number selects the group, fields are assembled with plain arithmetic.
  function automatic exp_t model(int k, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
    int     br_f3[6]  = '{0, 1, 4, 5, 6, 7};
    int     ld_f3[5]  = '{0, 1, 2, 4, 5};
    int     opi_f3[6] = '{0, 2, 3, 4, 6, 7};
    int     sh_f3[3]  = '{1, 5, 5};
    int     sh_f7[3]  = '{0, 0, 32};
    int     r_f3[10]  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int     r_f7[10]  = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    int     csr_f3[6] = '{1, 2, 3, 5, 6, 7};
    longint v = longint'($signed(imm));
    longint u = longint'({32'h0, imm});
    longint d = longint'(rd), a = longint'(rs1), b = longint'(rs2);
    longint w = 0;
    bit     ok = 1;
    exp_t   r;
    if (k == 0 || k == 1) begin
      ok = (u % 4096) == 0;
      w  = (u - (u % 4096)) + d * 128 + (k == 0 ? 'h37 : 'h17);
    end else if (k == 2) begin
      ok = v >= -(2**20) && v <= 2**20 - 2 && (v & 1) == 0;
      w  = (fld(v,20,20) << 31) | (fld(v,10,1) << 21) | (fld(v,11,11) << 20) | (fld(v,19,12) << 12) | (d << 7) | 'h6F;
    end else if (k == 3 || (k >= 10 && k <= 14) || (k >= 18 && k <= 23)) begin
      int f3 = (k == 3) ? 0 : (k <= 14) ? ld_f3[k-10] : opi_f3[k-18];
      int op = (k == 3) ? 'h67 : (k <= 14) ? 'h03 : 'h13;
      ok = v >= -2048 && v <= 2047;
      w  = (fld(v,11,0) << 20) | (a << 15) | (longint'(f3) << 12) | (d << 7) | op;
    end else if (k >= 4 && k <= 9) begin
      ok = v >= -4096 && v <= 4094 && (v & 1) == 0;
      w  = (fld(v,12,12) << 31) | (fld(v,10,5) << 25) | (b << 20) | (a << 15) | (longint'(br_f3[k-4]) << 12)
         | (fld(v,4,1) << 8) | (fld(v,11,11) << 7) | 'h63;
    end else if (k >= 15 && k <= 17) begin
      ok = v >= -2048 && v <= 2047;
      w  = (fld(v,11,5) << 25) | (b << 20) | (a << 15) | (longint'(k - 15) << 12) | (fld(v,4,0) << 7) | 'h23;
    end else if (k >= 24 && k <= 26) begin
      ok = u <= 31;
      w  = (longint'(sh_f7[k-24]) << 25) | (fld(v,4,0) << 20) | (a << 15) | (longint'(sh_f3[k-24]) << 12) | (d << 7) | 'h13;
    end else if (k >= 27 && k <= 36) begin
      w  = (longint'(r_f7[k-27]) << 25) | (b << 20) | (a << 15) | (longint'(r_f3[k-27]) << 12) | (d << 7) | 'h33;
    end else if (k == 37) begin
      ok = u < 256;
      w  = (u % 256) * (2**20) + 15;
    end else if (k == 38) w = 'h100F;
    else if (k == 39)     w = 'h73;
    else if (k == 40)     w = 'h100073;
    else if (k >= 41 && k <= 46) begin
      ok = u < 4096;
      w  = (u << 20) | (a << 15) | (longint'(csr_f3[k-41]) << 12) | (d << 7) | 'h73;
    end else ok = 0;
    r.err   = !ok;
    r.instr = ok ? w[31:0] : 32'h0;
    return r;
  endfunction

  task automatic drive(int k, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm, exp_t e);
    in_kind = instr_kind_t'(6'(k));
    in_rd   = rd;
    in_rs1  = rs1;
    in_rs2  = rs2;
    in_imm  = imm;
    nxt     = e;
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    check("accepted_count", 32'(accepted_count), 32'(sat(m_acc)));
    check("err_count", 32'(err_count), 32'(sat(m_err)));
    if (held) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_instr", out_instr, h_instr);
      check("hold_addr", out_addr, h_addr);
      check("hold_err", 32'(out_err), 32'(h_err));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h, expected no word outstanding", out_instr);
      end else begin
        e = q.pop_front();
        check("out_instr", out_instr, e.instr);
        check("out_err", 32'(out_err), 32'(e.err));
        check("out_addr", out_addr, m_addr);
        if (e.err) m_err++;
      end
      m_addr += 32'd4;
    end
    held    = out_valid && !out_ready;
    h_instr = out_instr;
    h_addr  = out_addr;
    h_err   = out_err;
    if (in_valid && in_ready) begin
      q.push_back(nxt);
      m_acc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_during_reset", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_addr = BASE; m_acc = 0; m_err = 0; held = 0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_addr", out_addr, BASE);
    check("reset_accepted", 32'(accepted_count), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain(string name);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words outstanding, expected 0", name, q.size());
    end
  endtask

  task automatic gen_random();
    int          k = $urandom_range(0, 49);
    logic [31:0] imm;
    logic [4:0]  rd = 5'($urandom), rs1 = 5'($urandom), rs2 = 5'($urandom);
    case ($urandom_range(0, 3))
      0:       imm = 32'($urandom_range(0, 8192)) - 32'd4096;
      1:       imm = $urandom;
      2:       imm = $urandom & 32'hFFFF_F000;
      default: imm = 32'($urandom_range(0, 300));
    endcase
    drive(k, rd, rs1, rs2, imm, model(k, rd, rs1, rs2, imm));
  endtask

  initial begin
    bit pend = 0;
    tbl.push_back('{int'(K_ADD),   5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 32'h0020_81B3});
    tbl.push_back('{int'(K_SUB),   5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 32'h4020_81B3});
    tbl.push_back('{int'(K_SRAI),  5'd1, 5'd1, 5'd0, 32'd3,          1'b0, 32'h4030_D093});
    tbl.push_back('{int'(K_LUI),   5'd5, 5'd0, 5'd0, 32'h1234_5000,  1'b0, 32'h1234_52B7});
    tbl.push_back('{int'(K_BEQ),   5'd0, 5'd1, 5'd2, 32'd8,          1'b0, 32'h0020_8463});
    tbl.push_back('{int'(K_BEQ),   5'd0, 5'd1, 5'd2, 32'd7,          1'b1, 32'h0});
    tbl.push_back('{int'(K_ADDI),  5'd1, 5'd0, 5'd0, 32'd2048,       1'b1, 32'h0});
    tbl.push_back('{int'(K_ADDI),  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF,  1'b0, 32'hFFF0_0093});
    tbl.push_back('{int'(K_ECALL), 5'd7, 5'd9, 5'd3, 32'h00AB_CDEF,  1'b0, 32'h0000_0073});
    tbl.push_back('{int'(K_EBREAK),5'd0, 5'd0, 5'd0, 32'd0,          1'b0, 32'h0010_0073});
    tbl.push_back('{int'(K_FENCE_I),5'd0,5'd0, 5'd0, 32'd0,          1'b0, 32'h0000_100F});
    tbl.push_back('{int'(K_FENCE), 5'd0, 5'd0, 5'd0, 32'h0000_00FF,  1'b0, 32'h0FF0_000F});
    tbl.push_back('{int'(K_FENCE), 5'd0, 5'd0, 5'd0, 32'h0000_0100,  1'b1, 32'h0});
    tbl.push_back('{int'(K_SLLI),  5'd1, 5'd1, 5'd0, 32'd32,         1'b1, 32'h0});
    tbl.push_back('{int'(K_JAL),   5'd1, 5'd0, 5'd0, 32'h000F_FFFE,  1'b0, 32'h7FFF_F0EF});
    tbl.push_back('{int'(K_JAL),   5'd1, 5'd0, 5'd0, 32'h0010_0000,  1'b1, 32'h0});
    tbl.push_back('{int'(K_CSRRW), 5'd1, 5'd2, 5'd0, 32'h0000_0300,  1'b0, 32'h3001_10F3});
    tbl.push_back('{int'(K_CSRRW), 5'd1, 5'd2, 5'd0, 32'h0000_1000,  1'b1, 32'h0});
    tbl.push_back('{63,            5'd1, 5'd2, 5'd3, 32'd0,          1'b1, 32'h0});
    tbl.push_back('{int'(K_SW),    5'd0, 5'd2, 5'd3, 32'hFFFF_FFFC,  1'b0, 32'hFE31_2E23});
    tbl.push_back('{int'(K_BNE),   5'd0, 5'd1, 5'd2, 32'hFFFF_F000,  1'b0, 32'h8020_9063});
    tbl.push_back('{int'(K_AUIPC), 5'd4, 5'd0, 5'd0, 32'h0000_1001,  1'b1, 32'h0});

    do_reset();

    // First word: two-cycle latency, address BASE.
    out_ready = 1'b1;
    drive(int'(K_ADDI), 5'd1, 5'd0, 5'd0, 32'd5, '{err: 1'b0, instr: 32'h0050_0093});
    in_valid = 1'b1;
    cycle();
    check("addi_accepted", 32'(s_in_ready), 32'd1);
    in_valid = 1'b0;
    cycle();
    check("latency_cycle1_valid", 32'(s_out_valid), 32'd0);
    cycle();
    check("latency_cycle2_valid", 32'(s_out_valid), 32'd1);
    drain("latency");

    // Vector table streamed at full rate; counters saturate at 2**CW-1 along the way.
    do_reset();
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].k, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, '{err: tbl[i].err, instr: tbl[i].instr});
      in_valid = 1'b1;
      cycle();
      check($sformatf("table%0d_in_ready", i), 32'(s_in_ready), 32'd1);
    end
    drain("table");

    // Backpressure: two accepts fill the pipe, third bundle waits until release.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(int'(K_ADDI), 5'(i + 1), 5'd2, 5'd0, 32'(i * 100), model(int'(K_ADDI), 5'(i + 1), 5'd2, 5'd0, 32'(i * 100)));
      cycle();
      check($sformatf("bp_in_ready%0d", i), 32'(s_in_ready), (i < 2) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_stall_in_ready", 32'(s_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    begin
      int n = 0;
      do begin cycle(); n++; end while (!s_in_ready && n < 10);
      check("bp_third_accepted", 32'(s_in_ready), 32'd1);
    end
    drain("backpressure");
    check("bp_accepted_count", 32'(accepted_count), 32'd3);

    // Reset with both stages full drops the in-flight words.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(int'(K_ADD), 5'd4, 5'd5, 5'd6, 32'd0, model(int'(K_ADD), 5'd4, 5'd5, 5'd6, 32'd0));
    cycle();
    drive(int'(K_OR), 5'd4, 5'd5, 5'd6, 32'd0, model(int'(K_OR), 5'd4, 5'd5, 5'd6, 32'd0));
    cycle();
    in_valid = 1'b0;
    cycle();
    check("full_before_reset", 32'(s_out_valid), 32'd1);
    do_reset();
    out_ready = 1'b1;
    drive(int'(K_ADDI), 5'd1, 5'd0, 5'd0, 32'd5, '{err: 1'b0, instr: 32'h0050_0093});
    in_valid = 1'b1;
    cycle();
    drain("post_reset");

    // Random traffic with random backpressure; a pending bundle is held until accepted.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!pend) begin
        gen_random();
        in_valid = ($urandom_range(0, 9) < 7);
      end
      out_ready = ($urandom_range(0, 9) < 6);
      cycle();
      pend = in_valid && !s_in_ready;
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder: packs an instr_kind_t plus rd/rs1/rs2/immediate operands into a 32-bit RV32I(+Zicsr, Zifencei) instruction word.
- Range-checks the immediate and flags illegal operands.
- Two-stage valid/ready pipeline with a running word address.
- Feeds instruction-memory preload and the self-checking bench, which round-trips encoder output through decode.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address tagged on the first emitted word after reset.
- CNT_W, 16: width of the saturating accepted/error counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand bundle valid
- in_ready  out  1  encoder can accept the bundle this cycle
- in_kind  in  instr_kind_t  instruction kind, from the opcode_type package
- in_rd  in  5  destination register
- in_rs1  in  5  source 1, or zimm for CSRR*I
- in_rs2  in  5  source 2
- in_imm  in  32  signed immediate; CSR address in [11:0] for CSR ops; pred/succ in [7:0] for FENCE
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts the word
- out_instr  out  32  encoded instruction
- out_addr  out  32  byte address of out_instr
- out_err  out  1  operands were illegal; out_instr forced to 32'h0
- accepted_count  out  CNT_W  saturating count of input handshakes
- err_count  out  CNT_W  saturating count of output handshakes with out_err=1

Behaviour:
- Reset: all registers clear synchronously on the clk edge where rst=1, overriding any handshake in that cycle. Reset values:
  - out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR
  - accepted_count=0, err_count=0
  - both stage valids=0
  - in_ready=0 while rst=1, then 1 from the first cycle after.
  - Reset mid-operation drops all in-flight words.
- Handshakes:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
  - out_instr, out_addr and out_err hold stable while out_valid && !out_ready.
- Stage S1:
  - Registers kind and operands.
  - Computes the range check and selects opcode, funct3 and funct7.
- Stage S2 (output register):
  - Packs the R/I/S/B/U/J field layout.
  - Advance rule: s2 loads when !s2_valid || out_ready.
  - in_ready = !s1_valid || s2 loads this cycle.
- Latency and throughput:
  - 2 cycles from input handshake to out_valid with out_ready held high.
  - Throughput 1 word/cycle.
  - At most 2 words in flight; no loss or reordering under any backpressure pattern.
- Address: out_addr increments by 4 on each output handshake, including error words. It wraps modulo 2^32.
- Immediate legality (violation gives out_err=1 and out_instr=0):
  - I-type (loads, ALU-imm, JALR): -2048..2047.
  - S-type: -2048..2047.
  - B-type: -4096..4094, and imm[0]=0.
  - J-type: -2^20..2^20-2, and imm[0]=0.
  - U-type: imm[11:0]=0; imm[31:12] goes to bits [31:12].
  - SLLI/SRLI/SRAI: 0..31. SRAI sets funct7=0100000.
  - CSR ops: imm[31:12]=0.
  - FENCE: imm[31:8]=0.
  - Kinds with unused fields (e.g. ECALL) ignore those inputs.
- Fixed encodings:
  - ECALL = 32'h0000_0073
  - EBREAK = 32'h0010_0073
  - FENCE_I = 32'h0000_100F
  - FENCE = {4'b0, imm[7:0], 13'b0, 7'b0001111}
- Unknown kind value: out_err=1.
- Counters:
  - accepted_count increments on each input handshake.
  - err_count increments on each output handshake with out_err=1.
  - Both saturate at all-ones and never wrap.
- Simultaneous events: an input and an output handshake in the same cycle with both stages full is legal (full-rate streaming).

Test Plan:
- ADDI rd=1 rs1=0 imm=5, out_ready=1 → out_valid two cycles later, out_instr=32'h0050_0093, out_addr=0, out_err=0.
- Stream ADD x3,x1,x2 / SUB x3,x1,x2 / SRAI x1,x1,3 back-to-back → 32'h0020_81B3, 32'h4020_81B3, 32'h4030_D093 on consecutive cycles; addresses 0, 4, 8.
- LUI rd=5 imm=32'h1234_5000 → 32'h1234_52B7. BEQ rs1=1 rs2=2 imm=8 → 32'h0020_8463. BEQ imm=7 → out_err=1, out_instr=0, err_count=1.
- ADDI imm=2048 → out_err=1, out_instr=0. Next ADDI imm=-1 rd=1 → 32'hFFF0_0093, out_err=0.
- out_ready=0 while 3 bundles are offered → in_ready falls after 2 accepts and outputs hold stable. Release → words emerge in order at addresses 0, 4, 8; accepted_count=3.
- rst pulsed for 1 cycle with both stages full → next cycle out_valid=0, out_addr=BASE_ADDR, counters=0. The first post-reset word carries out_addr=0.
